// File: rtl/zilla_fetch_redirect.sv
// zilla_fetch_redirect: fetch PC owner sitting between the branch resolver and
// the instruction-memory req/gnt port. It advances the PC on granted fetches,
// applies redirects without dropping a request that is already on the bus, and
// raises flush_o for FLUSH_DEPTH cycles per accepted redirect.
//
// Optional feature macro: ZILLA_MISALIGN_TRAP_EN
//   defined   : a target with branch_pc[1:0] != 0 is refused and reported
//               through misalign_err_o / misalign_addr_o
//   undefined : branch_pc[1:0] is forced to 00, misalign outputs tied low
//
// state      | meaning
// -----------+-----------------------------------------------------------
// BOOT       | first cycle after reset, no request issued
// RUN        | normal fetch, request = !stall_en
// HOLD_REDIR | redirect accepted while a request waits for its grant;
//            | address held until the grant, then target applied

module zilla_fetch_redirect #(
  parameter int                     PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int                     FLUSH_DEPTH = 2
) (
  input  logic                fr_clk,
  input  logic                fr_rst,
  input  logic                stall_en,
  input  logic                branch_en,
  input  logic [PC_WIDTH-1:0] branch_pc,
  output logic                if_req_o,
  output logic [PC_WIDTH-1:0] if_addr_o,
  input  logic                if_gnt_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                flush_o,
  output logic                misalign_err_o,
  output logic [PC_WIDTH-1:0] misalign_addr_o
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2
  } state_t;

  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] addr_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] redir_pc;
  logic [PC_WIDTH-1:0] redir_target;
  logic [2:0]          flush_cnt, flush_cnt_nxt;
  logic                flush_q;
  logic                misaligned;
  logic                branch_ok;
  logic                redir_accept;
  logic                fire;

`ifdef ZILLA_MISALIGN_TRAP_EN
  logic                trap;
  logic                err_q;
  logic [PC_WIDTH-1:0] err_addr_q;

  assign misaligned   = (branch_pc[1:0] != 2'b00);
  assign redir_target = branch_pc;
`else
  logic unused_low_bits;

  assign unused_low_bits = ^branch_pc[1:0];
  assign misaligned      = 1'b0;
  assign redir_target    = {branch_pc[PC_WIDTH-1:2], 2'b00};
`endif

  // Redirects are only taken in RUN; in HOLD_REDIR a redirect is already owed
  // and anything the resolver sends then comes from a wrong-path instruction.
  always_comb begin
    branch_ok    = branch_en && (flush_cnt == 3'd0) && !stall_en && (state == RUN);
    redir_accept = branch_ok && !misaligned;
    fire         = if_req_o && if_gnt_i;
  end

  // State register
  always_ff @(posedge fr_clk or posedge fr_rst) begin
    if (fr_rst) state <= BOOT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:       state_nxt = RUN;
      RUN:        if (redir_accept && if_req_o && !if_gnt_i) state_nxt = HOLD_REDIR;
      HOLD_REDIR: if (if_gnt_i) state_nxt = RUN;
      default:    state_nxt = BOOT;
    endcase
  end

  // Request decode: a held request stays on the bus even under stall
  always_comb begin
    if_req_o = 1'b0;
    case (state)
      RUN:        if_req_o = !stall_en;
      HOLD_REDIR: if_req_o = 1'b1;
      default:    if_req_o = 1'b0;
    endcase
  end

  // Fetch address, granted PC and pending redirect target
  always_ff @(posedge fr_clk or posedge fr_rst) begin
    if (fr_rst) begin
      addr_q   <= RESET_PC;
      pc_q     <= RESET_PC;
      redir_pc <= '0;
    end else begin
      if (fire) pc_q <= addr_q;
      case (state)
        RUN: begin
          if (redir_accept) begin
            redir_pc <= redir_target;
            if (!if_req_o || if_gnt_i) addr_q <= redir_target;
          end else if (fire) begin
            addr_q <= addr_q + PC_STEP;
          end
        end
        HOLD_REDIR: if (if_gnt_i) addr_q <= redir_pc;
        default: ;
      endcase
    end
  end

  // Flush counter: loaded on accept, drains every cycle regardless of stall
  always_comb begin
    flush_cnt_nxt = flush_cnt;
    if (redir_accept)            flush_cnt_nxt = FLUSH_LOAD;
    else if (flush_cnt != 3'd0)  flush_cnt_nxt = flush_cnt - 3'd1;
  end

  // Flush counter and registered flush flag
  always_ff @(posedge fr_clk or posedge fr_rst) begin
    if (fr_rst) begin
      flush_cnt <= 3'd0;
      flush_q   <= 1'b0;
    end else begin
      flush_cnt <= flush_cnt_nxt;
      flush_q   <= (flush_cnt_nxt != 3'd0);
    end
  end

`ifdef ZILLA_MISALIGN_TRAP_EN
  assign trap = branch_ok && misaligned;

  // Misaligned-target report: one-cycle pulse, address kept until next trap
  always_ff @(posedge fr_clk or posedge fr_rst) begin
    if (fr_rst) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q <= trap;
      if (trap) err_addr_q <= branch_pc;
    end
  end

  assign misalign_err_o  = err_q;
  assign misalign_addr_o = err_addr_q;
`else
  assign misalign_err_o  = 1'b0;
  assign misalign_addr_o = '0;
`endif

  assign if_addr_o = addr_q;
  assign pc_o      = pc_q;
  assign flush_o   = flush_q;

endmodule

// File: tb/tb_zilla_fetch_redirect.sv
// Bench for zilla_fetch_redirect: one cycle per table row, expected outputs
// queued when the row is driven and compared before the next rising edge.
// Hand-written tail covers asynchronous reset during a held redirect.

module tb_zilla_fetch_redirect;

  logic        fr_clk = 1'b0;
  logic        fr_rst;
  logic        stall_en;
  logic        branch_en;
  logic [31:0] branch_pc;
  logic        if_req_o;
  logic [31:0] if_addr_o;
  logic        if_gnt_i;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        misalign_err_o;
  logic [31:0] misalign_addr_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] bpc;
    logic        gnt;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        flush;
    logic        err;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  zilla_fetch_redirect dut (
    .fr_clk          (fr_clk),
    .fr_rst          (fr_rst),
    .stall_en        (stall_en),
    .branch_en       (branch_en),
    .branch_pc       (branch_pc),
    .if_req_o        (if_req_o),
    .if_addr_o       (if_addr_o),
    .if_gnt_i        (if_gnt_i),
    .pc_o            (pc_o),
    .flush_o         (flush_o),
    .misalign_err_o  (misalign_err_o),
    .misalign_addr_o (misalign_addr_o)
  );

  always #5 fr_clk = ~fr_clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic br, input logic [31:0] bpc, input logic gnt,
                     input logic req, input logic [31:0] addr, input logic [31:0] pc,
                     input logic fl, input logic err, input logic [31:0] maddr);
    vec_t v;
    v.stall = st; v.br = br; v.bpc = bpc; v.gnt = gnt;
    v.req = req; v.addr = addr; v.pc = pc; v.flush = fl; v.err = err; v.maddr = maddr;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    logic [31:0] held_addr;

    // stall br  bpc           gnt | req addr          pc            flush err maddr
    add(0, 0, 32'h0,        1,   0, 32'h0,        32'h0,        0, 0, 32'h0);   // c0 BOOT
    add(0, 0, 32'h0,        1,   1, 32'h0,        32'h0,        0, 0, 32'h0);   // c1
    add(0, 0, 32'h0,        1,   1, 32'h4,        32'h0,        0, 0, 32'h0);   // c2
    add(0, 1, 32'h100,      1,   1, 32'h8,        32'h4,        0, 0, 32'h0);   // c3 redirect
    add(0, 1, 32'h300,      1,   1, 32'h100,      32'h8,        1, 0, 32'h0);   // c4 ignored
    add(0, 0, 32'h0,        1,   1, 32'h104,      32'h100,      1, 0, 32'h0);   // c5
    add(0, 1, 32'h40,       1,   1, 32'h108,      32'h104,      0, 0, 32'h0);   // c6 redirect
    add(0, 0, 32'h0,        1,   1, 32'h40,       32'h108,      1, 0, 32'h0);   // c7
    add(0, 0, 32'h0,        1,   1, 32'h44,       32'h40,       1, 0, 32'h0);   // c8
    add(0, 1, 32'h200,      1,   1, 32'h48,       32'h44,       0, 0, 32'h0);   // c9
    add(0, 0, 32'h0,        0,   1, 32'h200,      32'h48,       1, 0, 32'h0);   // c10 no grant
    add(0, 0, 32'h0,        0,   1, 32'h200,      32'h48,       1, 0, 32'h0);   // c11
    add(0, 1, 32'h80,       0,   1, 32'h200,      32'h48,       0, 0, 32'h0);   // c12 -> HOLD
    add(0, 1, 32'h300,      0,   1, 32'h200,      32'h48,       1, 0, 32'h0);   // c13 ignored
    add(0, 0, 32'h0,        1,   1, 32'h200,      32'h48,       1, 0, 32'h0);   // c14 grant
    add(0, 0, 32'h0,        1,   1, 32'h80,       32'h200,      0, 0, 32'h0);   // c15
    add(0, 1, 32'hFFFFFFF8, 1,   1, 32'h84,       32'h80,       0, 0, 32'h0);   // c16
    add(0, 0, 32'h0,        1,   1, 32'hFFFFFFF8, 32'h84,       1, 0, 32'h0);   // c17
    add(0, 0, 32'h0,        1,   1, 32'hFFFFFFFC, 32'hFFFFFFF8, 1, 0, 32'h0);   // c18 wrap
    add(1, 0, 32'h0,        1,   0, 32'h0,        32'hFFFFFFFC, 0, 0, 32'h0);   // c19 stall
    add(1, 1, 32'h500,      1,   0, 32'h0,        32'hFFFFFFFC, 0, 0, 32'h0);   // c20 stall+br
    add(0, 0, 32'h0,        1,   1, 32'h0,        32'hFFFFFFFC, 0, 0, 32'h0);   // c21
    add(0, 0, 32'h0,        0,   1, 32'h4,        32'h0,        0, 0, 32'h0);   // c22
    add(0, 1, 32'h600,      0,   1, 32'h4,        32'h0,        0, 0, 32'h0);   // c23 -> HOLD
    add(1, 0, 32'h0,        0,   1, 32'h4,        32'h0,        1, 0, 32'h0);   // c24 stall in HOLD
    add(1, 0, 32'h0,        1,   1, 32'h4,        32'h0,        1, 0, 32'h0);   // c25 grant
    add(1, 0, 32'h0,        1,   0, 32'h600,      32'h4,        0, 0, 32'h0);   // c26
    add(0, 0, 32'h0,        1,   1, 32'h600,      32'h4,        0, 0, 32'h0);   // c27
`ifdef ZILLA_MISALIGN_TRAP_EN
    add(0, 1, 32'h42,       1,   1, 32'h604,      32'h600,      0, 0, 32'h0);   // c28 trap
    add(0, 0, 32'h0,        1,   1, 32'h608,      32'h604,      0, 1, 32'h42);  // c29
    add(0, 0, 32'h0,        1,   1, 32'h60C,      32'h608,      0, 0, 32'h42);  // c30
    add(0, 0, 32'h0,        1,   1, 32'h610,      32'h60C,      0, 0, 32'h42);  // c31
    held_addr = 32'h614;
`else
    add(0, 1, 32'h42,       1,   1, 32'h604,      32'h600,      0, 0, 32'h0);   // c28 -> 0x40
    add(0, 0, 32'h0,        1,   1, 32'h40,       32'h604,      1, 0, 32'h0);   // c29
    add(0, 0, 32'h0,        1,   1, 32'h44,       32'h40,       1, 0, 32'h0);   // c30
    add(0, 0, 32'h0,        1,   1, 32'h48,       32'h44,       0, 0, 32'h0);   // c31
    held_addr = 32'h4C;
`endif

    fr_rst    = 1'b1;
    stall_en  = 1'b0;
    branch_en = 1'b0;
    branch_pc = 32'h0;
    if_gnt_i  = 1'b1;
    repeat (2) @(negedge fr_clk);
    chk("rst_req",   -1, 32'(if_req_o),  32'h0);
    chk("rst_addr",  -1, if_addr_o,      32'h0);
    chk("rst_pc",    -1, pc_o,           32'h0);
    chk("rst_flush", -1, 32'(flush_o),   32'h0);
    @(posedge fr_clk);
    #2 fr_rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge fr_clk);
      stall_en  = vecs[i].stall;
      branch_en = vecs[i].br;
      branch_pc = vecs[i].bpc;
      if_gnt_i  = vecs[i].gnt;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      chk("req",   i, 32'(if_req_o),       32'(e.req));
      chk("addr",  i, if_addr_o,           e.addr);
      chk("pc",    i, pc_o,                e.pc);
      chk("flush", i, 32'(flush_o),        32'(e.flush));
      chk("err",   i, 32'(misalign_err_o), 32'(e.err));
      chk("maddr", i, misalign_addr_o,     e.maddr);
    end

    // Enter HOLD_REDIR, then reset asynchronously mid-cycle.
    @(negedge fr_clk);
    stall_en  = 1'b0;
    if_gnt_i  = 1'b0;
    branch_en = 1'b1;
    branch_pc = 32'h700;
    @(negedge fr_clk);
    branch_en = 1'b0;
    #1;
    chk("hold_req",   100, 32'(if_req_o), 32'h1);
    chk("hold_addr",  100, if_addr_o,     held_addr);
    chk("hold_flush", 100, 32'(flush_o),  32'h1);
    #2 fr_rst = 1'b1;
    #1;
    chk("arst_req",   101, 32'(if_req_o),  32'h0);
    chk("arst_addr",  101, if_addr_o,      32'h0);
    chk("arst_pc",    101, pc_o,           32'h0);
    chk("arst_flush", 101, 32'(flush_o),   32'h0);
    chk("arst_maddr", 101, misalign_addr_o, 32'h0);
    @(negedge fr_clk);
    fr_rst   = 1'b0;
    if_gnt_i = 1'b1;
    #1;
    chk("boot_req", 102, 32'(if_req_o), 32'h0);
    @(negedge fr_clk);
    #1;
    chk("first_req",  103, 32'(if_req_o), 32'h1);
    chk("first_addr", 103, if_addr_o,     32'h0);
    @(negedge fr_clk);
    #1;
    chk("next_addr",  104, if_addr_o,     32'h4);
    chk("next_pc",    104, pc_o,          32'h0);
    chk("next_flush", 104, 32'(flush_o),  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zilla_fetch_redirect.md
# zilla_fetch_redirect

Fetch-side program-counter unit that consumes the branch/jump redirect (`branch_en`, `branch_pc`) from the decode-stage branch resolver. It owns the fetch PC, issues word fetches to instruction memory over a req/gnt handshake, applies redirects without breaking an in-flight request, and flushes the younger wrong-path instructions. It sits between the branch resolver and the instruction-memory port, ahead of the IF/ID pipeline register.

## Interface
- `PC_WIDTH`, 32, width of PC and fetch address
- `RESET_PC`, 0, first fetch address after reset
- `FLUSH_DEPTH`, 2, cycles `flush_o` stays high per accepted redirect (1..7)
- `fr_clk` in 1: single clock, all logic on rising edge
- `fr_rst` in 1: asynchronous, active-high reset
- `stall_en` in 1: pipeline stall; freezes PC advance and suppresses new requests
- `branch_en` in 1: redirect strobe from branch resolver, one cycle
- `branch_pc` in PC_WIDTH: redirect target, valid with `branch_en`
- `if_req_o` out 1: fetch request
- `if_addr_o` out PC_WIDTH: fetch address, stable while `if_req_o && !if_gnt_i`
- `if_gnt_i` in 1: memory accepted the request this cycle
- `pc_o` out PC_WIDTH: address of last granted fetch (for IF/ID)
- `flush_o` out 1: kill IF/ID contents
- `misalign_err_o` out 1: one-cycle pulse, misaligned target (macro only)
- `misalign_addr_o` out PC_WIDTH: captured misaligned target (macro only)

## Operation
- States: BOOT, RUN, HOLD_REDIR.
- BOOT: entered on reset; `if_req_o`=0 for one cycle, then RUN with `if_addr_o`=RESET_PC.
- RUN: `if_req_o` = !stall_en. On `if_req_o && if_gnt_i`: `pc_o` <= `if_addr_o`, `if_addr_o` <= `if_addr_o`+4 (modulo 2^PC_WIDTH, wraps to 0).
- Redirect accept: `branch_en`=1 and flush counter = 0 and not stalled. Target latched into `redir_pc`; flush counter loaded with FLUSH_DEPTH.
  - If no request is pending ungranted (`!if_req_o || if_gnt_i`): next `if_addr_o` = `redir_pc`; stay RUN.
  - Else: HOLD_REDIR; `if_addr_o` held until `if_gnt_i`; on grant, next `if_addr_o` = `redir_pc`, back to RUN. The granted wrong-path fetch is covered by the flush.
- `branch_en` while flush counter != 0 is ignored (it comes from a killed instruction).
- `branch_en` while `stall_en`=1 is ignored; the resolver re-presents it after the stall.
- Flush: `flush_o` = (flush counter != 0); counter decrements each cycle regardless of stall.
- Stall in HOLD_REDIR: request already on the bus remains asserted until granted (handshake rule beats stall); after the grant, no new request while stalled.
- Reset mid-operation: all state cleared asynchronously; any pending redirect is discarded.

## Timing
- Reset values: `if_req_o`=0, `if_addr_o`=RESET_PC, `pc_o`=RESET_PC, `flush_o`=0, `misalign_err_o`=0, `misalign_addr_o`=0; state BOOT.
- First request: second rising edge after `fr_rst` deasserts.
- Redirect latency: `branch_en` at edge N; `flush_o` high from N+1 for FLUSH_DEPTH cycles; `if_addr_o`=target at N+1 (RUN) or the cycle after the held request's grant (HOLD_REDIR).
- Grant and redirect in the same cycle: grant completes the old address; the target is the next address (no HOLD_REDIR).
- All outputs registered except `if_req_o` (combinational from state and `stall_en`).

## Configuration
- `ZILLA_MISALIGN_TRAP_EN` defined: target with `branch_pc[1:0]` != 0 is not accepted as a redirect: no flush, no PC change, `misalign_err_o` pulses one cycle at N+1, and `misalign_addr_o` captures the target.
- Not defined: `branch_pc[1:0]` is forced to 00 and the redirect proceeds normally; `misalign_err_o`/`misalign_addr_o` are tied 0.

## Test plan
- Reset release, `if_gnt_i`=1 constantly -> `if_req_o` low one cycle, then addresses 0x0, 0x4, 0x8 on consecutive cycles; `flush_o`=0.
- RUN at 0x100 with grant; `branch_en`, `branch_pc`=0x40 -> next `if_addr_o`=0x40, `flush_o` high exactly 2 cycles.
- Request 0x200 pending with `if_gnt_i`=0 for 3 cycles; `branch_en`, `branch_pc`=0x80 -> `if_addr_o` stays 0x200 until grant, then 0x80; flush counted from the `branch_en` edge.
- Second `branch_en` (0x300) one cycle after the first (0x80) -> second ignored; fetch continues 0x80, 0x84.
- PC at 0xFFFFFFFC granted -> next `if_addr_o`=0x0; `stall_en`=1 for 2 cycles -> `if_req_o`=0 and address frozen.
- `branch_pc`=0x42: with `ZILLA_MISALIGN_TRAP_EN` -> `misalign_err_o` one pulse, `misalign_addr_o`=0x42, no flush; without the macro -> redirect to 0x40 with flush.
